// File: rtl/ikaopm_dac_pkg.sv
// rtl/ikaopm_dac_pkg.sv - shared constants, float-word layout and FSM states for the DAC receiver
// Contents:
//   FRAME_BITS_DEFAULT : serial bits per channel word, pad bits included
//   PAD_BITS, MANT_W, EXP_W : field widths of the received floating-point word
//   fp_word_t          : packed view of the 16-bit word {exponent, mantissa, pad}
//   rx_state_t         : receiver FSM states

package ikaopm_dac_pkg;

    localparam int FRAME_BITS_DEFAULT = 16;
    localparam int PAD_BITS           = 3;
    localparam int MANT_W             = 10;
    localparam int EXP_W              = 3;

    // MSB-first field order; the serial stream arrives LSB first, so the pad
    // bits are the first on the wire and the exponent bits are the last.
    typedef struct packed {
        logic [EXP_W-1:0]    expo;
        logic [MANT_W-1:0]   mant;
        logic [PAD_BITS-1:0] pad;
    } fp_word_t;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } rx_state_t;

endpackage

// File: rtl/ikaopm_dac_fp2lin.sv
// rtl/ikaopm_dac_fp2lin.sv - combinational DAC float word to 16-bit signed linear conversion
// Ports:
//   word : received float word (exponent, offset-binary mantissa, pad)
//   lin  : signed linear sample, zero when the exponent is zero

module ikaopm_dac_fp2lin
    import ikaopm_dac_pkg::*;
(
    input  fp_word_t    word,
    output logic [15:0] lin
);

    logic [15:0] mant_ext;
    logic        unused_pad;

    // The mantissa is offset binary: inverting D9 turns it into two's
    // complement, and that inverted bit is also the sign for extension.
    assign mant_ext   = {{7{~word.mant[MANT_W-1]}}, word.mant[MANT_W-2:0]};
    assign unused_pad = ^word.pad;

    always_comb begin
        lin = 16'd0;
        if (word.expo != 3'd0) begin
            lin = mant_ext << (word.expo - 3'd1);
        end
    end

endmodule

// File: rtl/ikaopm_dac_rx.sv
// rtl/ikaopm_dac_rx.sv - serial OPM DAC stream receiver producing left/right linear samples
// Optional feature macro: IKAOPM_DAC_RX_ERRCHK_EN (frame-length counter and sticky error flag)
// Ports:
//   i_EMUCLK            : master clock, rising edge
//   i_RST               : synchronous active-high reset
//   i_CEN_n             : active-low bit-clock enable, one serial bit per enabled cycle
//   i_SO                : serial data, LSB first
//   i_SH1 / i_SH2       : left / right latch strobes, falling edge latches
//   o_L / o_R           : signed linear samples
//   o_L_VALID/o_R_VALID : one-cycle new-sample pulses
//   o_FRAME_ERR         : sticky frame-length error (tied low without the macro)

module ikaopm_dac_rx
    import ikaopm_dac_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEFAULT
) (
    input  logic        i_EMUCLK,
    input  logic        i_RST,
    input  logic        i_CEN_n,
    input  logic        i_SO,
    input  logic        i_SH1,
    input  logic        i_SH2,
    output logic [15:0] o_L,
    output logic [15:0] o_R,
    output logic        o_L_VALID,
    output logic        o_R_VALID,
    output logic        o_FRAME_ERR
);

    logic [15:0] shift_q;
    logic        sh1_prev;
    logic        sh2_prev;
    rx_state_t   state_q;
    rx_state_t   state_d;

    logic        cen;
    logic        fall_l;
    logic        fall_r;
    logic        any_fall;
    logic        emit;
    logic [15:0] lin_l;
    logic [15:0] lin_r;

    assign cen      = ~i_CEN_n;
    // Strobe history only advances on enabled cycles, so edges are seen at bit rate.
    assign fall_l   = cen & sh1_prev & ~i_SH1;
    assign fall_r   = cen & sh2_prev & ~i_SH2;
    assign any_fall = fall_l | fall_r;
    assign emit     = (state_q == ST_RUN);

    // Both channels convert the same pre-shift word; which one is kept is
    // decided by the strobe that fell.
    ikaopm_dac_fp2lin u_fp2lin_l (
        .word (fp_word_t'(shift_q)),
        .lin  (lin_l)
    );

    ikaopm_dac_fp2lin u_fp2lin_r (
        .word (fp_word_t'(shift_q)),
        .lin  (lin_r)
    );

    always_comb begin
        state_d = state_q;
        // The first strobe after reset only marks frame alignment.
        if (state_q == ST_SYNC && any_fall) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state_q   <= ST_SYNC;
            shift_q   <= 16'd0;
            sh1_prev  <= 1'b0;
            sh2_prev  <= 1'b0;
            o_L       <= 16'd0;
            o_R       <= 16'd0;
            o_L_VALID <= 1'b0;
            o_R_VALID <= 1'b0;
        end else begin
            state_q   <= state_d;
            o_L_VALID <= 1'b0;
            o_R_VALID <= 1'b0;
            if (cen) begin
                shift_q  <= {i_SO, shift_q[15:1]};
                sh1_prev <= i_SH1;
                sh2_prev <= i_SH2;
            end
            if (fall_l && emit) begin
                o_L       <= lin_l;
                o_L_VALID <= 1'b1;
            end
            if (fall_r && emit) begin
                o_R       <= lin_r;
                o_R_VALID <= 1'b1;
            end
        end
    end

`ifdef IKAOPM_DAC_RX_ERRCHK_EN
    logic [4:0] cnt_q;

    // The strobe cycle itself counts as the first bit of the next frame.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            cnt_q       <= 5'd0;
            o_FRAME_ERR <= 1'b0;
        end else if (cen) begin
            if (any_fall) begin
                cnt_q <= 5'd1;
                if (emit && int'(cnt_q) != FRAME_BITS) begin
                    o_FRAME_ERR <= 1'b1;
                end
            end else if (cnt_q != 5'd31) begin
                cnt_q <= cnt_q + 5'd1;
            end
        end
    end
`else
    logic unused_frame_bits;

    assign unused_frame_bits = ^5'(FRAME_BITS);
    assign o_FRAME_ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_ikaopm_dac_rx.sv
// tb/tb_ikaopm_dac_rx.sv - self-checking bench for the OPM DAC stream receiver

module tb_ikaopm_dac_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        cen_n;
    logic        so;
    logic        sh1;
    logic        sh2;
    logic [15:0] o_l;
    logic [15:0] o_r;
    logic        vl;
    logic        vr;
    logic        err;

    always #5 clk = ~clk;

`ifdef IKAOPM_DAC_RX_ERRCHK_EN
    localparam logic ERRCHK = 1'b1;
`else
    localparam logic ERRCHK = 1'b0;
`endif

    ikaopm_dac_rx #(.FRAME_BITS(16)) dut (
        .i_EMUCLK    (clk),
        .i_RST       (rst),
        .i_CEN_n     (cen_n),
        .i_SO        (so),
        .i_SH1       (sh1),
        .i_SH2       (sh2),
        .o_L         (o_l),
        .o_R         (o_r),
        .o_L_VALID   (vl),
        .o_R_VALID   (vr),
        .o_FRAME_ERR (err)
    );

    typedef struct {
        logic [2:0]  e;
        logic [9:0]  d;
        logic [1:0]  mask;
        logic [15:0] exp_lin;
    } vec_t;

    vec_t        tbl[9];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] q_l[$];
    logic [15:0] q_r[$];
    logic [15:0] sr_model;
    logic        run;
    logic [15:0] last_l;
    logic [15:0] last_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] word_of(input vec_t v);
        return {v.e, v.d, 3'b101};
    endfunction

    // Reference conversion written arithmetically: offset-binary mantissa times 2^(e-1).
    function automatic logic [15:0] model(input logic [15:0] w);
        int e;
        int m;
        e = int'(w[15:13]);
        m = int'(w[11:3]) - (w[12] ? 0 : 512);
        if (e == 0) return 16'd0;
        return 16'(m * (1 << (e - 1)));
    endfunction

    task automatic sample();
        if (vl) begin
            if (q_l.size() == 0) check("l_valid_unexpected", vl, 1'b0);
            else check("o_l_value", o_l, q_l.pop_front());
        end
        if (vr) begin
            if (q_r.size() == 0) check("r_valid_unexpected", vr, 1'b0);
            else check("o_r_value", o_r, q_r.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        sample();
    endtask

    // One enabled bit, sometimes preceded by a disabled cycle carrying junk
    // (strobes low, random data) that must not be sampled.
    task automatic drive_en(input logic so_v, input logic sh1_v, input logic sh2_v);
        if ($urandom_range(0, 2) == 0) begin
            cen_n = 1'b1;
            so    = 1'($urandom);
            sh1   = 1'b0;
            sh2   = 1'b0;
            tick();
        end
        cen_n = 1'b0;
        so    = so_v;
        sh1   = sh1_v;
        sh2   = sh2_v;
        tick();
        sr_model = {so_v, sr_model[15:1]};
    endtask

    // Sends bits [nbits-1:1] then a strobe cycle; the strobe cycle's own bit
    // (0) becomes pad bit 0 of the following word.
    task automatic send_word(input logic [15:0] w, input int nbits, input logic [1:0] mask,
                             input logic use_tbl, input logic [15:0] tbl_exp);
        logic [15:0] req;
        for (int i = 1; i < nbits; i++) drive_en(w[i], 1'b1, 1'b1);
        req = use_tbl ? tbl_exp : model(sr_model);
        if (run) begin
            if (mask[0]) q_l.push_back(req);
            if (mask[1]) q_r.push_back(req);
        end
        if (mask != 2'b00) run = 1'b1;
        drive_en(1'b0, ~mask[0], ~mask[1]);
        check("l_valid_latency", q_l.size(), 0);
        check("r_valid_latency", q_r.size(), 0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_o_l"}, o_l, 16'd0);
        check({tag, "_o_r"}, o_r, 16'd0);
        check({tag, "_l_valid"}, vl, 1'b0);
        check({tag, "_r_valid"}, vr, 1'b0);
        check({tag, "_frame_err"}, err, 1'b0);
    endtask

    initial begin
        tbl[0] = '{3'd7, 10'h3FF, 2'b01, 16'h7FC0};
        tbl[1] = '{3'd1, 10'h000, 2'b10, 16'hFE00};
        tbl[2] = '{3'd0, 10'h2AB, 2'b10, 16'h0000};
        tbl[3] = '{3'd3, 10'h155, 2'b11, 16'hFD54};
        tbl[4] = '{3'd7, 10'h000, 2'b01, 16'h8000};
        tbl[5] = '{3'd2, 10'h200, 2'b01, 16'h0000};
        tbl[6] = '{3'd5, 10'h201, 2'b10, 16'h0010};
        tbl[7] = '{3'd4, 10'h1FF, 2'b11, 16'hFFF8};
        tbl[8] = '{3'd6, 10'h2AA, 2'b01, 16'h1540};

        rst = 1'b1; cen_n = 1'b1; so = 1'b0; sh1 = 1'b1; sh2 = 1'b1;
        sr_model = 16'd0; run = 1'b0; last_l = 16'd0; last_r = 16'd0;
        tick();
        tick();
        rst = 1'b0;
        check_cleared("reset");

        // First strobe after reset only aligns; no sample may appear.
        send_word(word_of(tbl[0]), 16, 2'b11, 1'b1, tbl[0].exp_lin);
        check("sync_o_l", o_l, 16'd0);
        check("sync_o_r", o_r, 16'd0);

        for (int i = 0; i < 9; i++) begin
            send_word(word_of(tbl[i]), 16, tbl[i].mask, 1'b1, tbl[i].exp_lin);
            if (tbl[i].mask[0]) last_l = tbl[i].exp_lin;
            if (tbl[i].mask[1]) last_r = tbl[i].exp_lin;
        end
        check("err_after_good_frames", err, 1'b0);

        // Strobes toggling while the bit clock is disabled must be ignored.
        for (int i = 0; i < 6; i++) begin
            cen_n = 1'b1;
            sh1   = i[0];
            sh2   = i[0];
            tick();
        end
        check("hold_o_l", o_l, last_l);
        check("hold_o_r", o_r, last_r);

        // Short frame: 15 bits between strobes.
        send_word(word_of(tbl[8]), 15, 2'b01, 1'b0, 16'd0);
        check("err_short_frame", err, ERRCHK);
        send_word(word_of(tbl[1]), 16, 2'b10, 1'b1, tbl[1].exp_lin);
        check("err_sticky", err, ERRCHK);
        send_word(word_of(tbl[6]), 16, 2'b01, 1'b1, tbl[6].exp_lin);
        check("err_sticky2", err, ERRCHK);

        // Reset after 8 bits, coincident with a falling strobe.
        for (int i = 0; i < 8; i++) drive_en(i[0], 1'b1, 1'b1);
        rst = 1'b1; cen_n = 1'b0; so = 1'b1; sh1 = 1'b0; sh2 = 1'b0;
        tick();
        rst = 1'b0; sh1 = 1'b1; sh2 = 1'b1;
        sr_model = 16'd0; run = 1'b0;
        check_cleared("midframe_reset");

        send_word(word_of(tbl[4]), 16, 2'b11, 1'b1, tbl[4].exp_lin);
        check("resync_o_l", o_l, 16'd0);
        check("resync_o_r", o_r, 16'd0);
        send_word(word_of(tbl[3]), 16, 2'b11, 1'b1, tbl[3].exp_lin);
        check("both_equal", o_l, o_r);
        check("both_value", o_l, tbl[3].exp_lin);
        check("err_after_reset", err, 1'b0);

        cen_n = 1'b1;
        tick();
        tick();
        check("queue_l_drained", q_l.size(), 0);
        check("queue_r_drained", q_r.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
